card_cursor_select: RTL and testbench
=====================================

Name: card_cursor_select

Overview:
- Upstream input stage for gameplay_sm.
- Converts single-cycle button pulses into a cursor position on the 4x4 card grid.
- On a centre press, reads the card word at the cursor from board memory, rejects face-up or matched cards, and otherwise presents the card to gameplay_sm on Select / CardSelectData / CardSelectLoc.
- Holds that request until gameplay_sm returns Ack.

Parameters:
- GRID_W, 4, columns in grid (power of 2)
- GRID_H, 4, rows in grid (power of 2)
- LOC_W, 4, location width = log2(GRID_W*GRID_H)
- DATA_W, 6, card word width; bit 5 = matched, bit 4 = face-up, bits 3:0 = card value
- RD_LAT, 1, board memory read latency in cycles (1..3)

Ports:
- Clk  input  1  system clock, all logic on rising edge
- Reset  input  1  synchronous, active-low reset (sampled on Clk rising edge; 0 = reset)
- Enable  input  1  gameplay_sm is accepting selections
- BtnL  input  1  move-left pulse (one cycle, already debounced)
- BtnR  input  1  move-right pulse
- BtnU  input  1  move-up pulse
- BtnD  input  1  move-down pulse
- BtnC  input  1  select pulse
- RamAddr  output  LOC_W  board memory read address
- RamData  input  DATA_W  board memory read data, valid RD_LAT cycles after RamAddr
- Select  output  1  selection request to gameplay_sm
- CardSelectData  output  DATA_W  card word of the request
- CardSelectLoc  output  LOC_W  grid location of the request
- Ack  input  1  gameplay_sm accepted the request
- Cursor  output  LOC_W  current cursor location (to display)
- Reject  output  1  one-cycle pulse: selection refused
- SelState  output  2  FSM state for debug: 0 IDLE, 1 READ, 2 CHECK, 3 REQ

Behaviour:
- **Reset (Reset=0 at edge):**
  - State IDLE.
  - Cursor=0, Select=0, Reject=0, CardSelectData=0, CardSelectLoc=0, read counter=0.
  - Reset overrides everything, including an outstanding REQ; Select is low the cycle after the reset edge.
- **Location encoding:** loc = row*GRID_W + col. RamAddr is driven combinationally as Cursor.
- **IDLE:**
  - Moves apply only in IDLE. L: col-1, R: col+1, U: row-1, D: row+1.
  - Moves wrap within their row/column: col 0 left -> col GRID_W-1; row GRID_H-1 down -> row 0.
  - If several move buttons are high in one cycle, only the highest priority is applied: L > R > U > D.
  - BtnC with Enable=1 has priority over any move in the same cycle: Cursor is unchanged, CardSelectLoc<=Cursor, go to READ.
  - BtnC with Enable=0 is ignored (no Reject).
- **READ:**
  - Wait RD_LAT cycles.
  - On the RD_LAT-th edge, capture RamData into CardSelectData and go to CHECK.
  - Button pulses are ignored.
- **CHECK (one cycle):**
  - If CardSelectData[5]=1 or CardSelectData[4]=1: Reject=1 for exactly the next cycle, go to IDLE.
  - Otherwise go to REQ with Select=1.
- **REQ:**
  - Select=1; CardSelectData and CardSelectLoc are held stable.
  - When Ack=1 is sampled: Select=0 the next cycle, go to IDLE.
  - Enable falling during REQ does not abort the request.
  - Buttons are ignored.
- **Latency:** Select rises RD_LAT+1 cycles after the edge that sampled BtnC. Reject rises at the same point.
- **Ack handling:** Ack outside REQ is ignored. Ack in the same cycle Select first rises is valid, giving a one-cycle request.
- **Register timing:** Cursor, Select, Reject, CardSelectData and CardSelectLoc are all registered outputs.

Test Plan:
- **Reset then wrap:** Reset=0 for 2 cycles then Reset=1; BtnL once -> Cursor=3; BtnU once -> Cursor=15; BtnD once -> Cursor=3.
- **Move priority:** from Cursor=5, BtnL=BtnR=BtnD=1 in the same cycle -> Cursor=4 only. BtnC+BtnR same cycle with Enable=1 -> Cursor unchanged, SelState=READ next cycle.
- **Valid select:** Cursor=6, memory[6]=6'h0A, RD_LAT=1, Enable=1, BtnC pulse -> Select=1 two cycles later with CardSelectData=6'h0A and CardSelectLoc=6. Hold Ack=0 for 5 cycles -> outputs stable. Ack=1 -> Select=0 next cycle, SelState=IDLE.
- **Reject:** memory[2]=6'h23 (matched) and memory[3]=6'h17 (face-up); select each -> Reject one-cycle pulse, Select never rises, SelState returns to IDLE.
- **Gating:** BtnC with Enable=0 -> no state change. Enable dropped during REQ -> Select stays high until Ack. Moves during READ/REQ -> Cursor unchanged. Ack pulses in IDLE -> no effect.
- **Reset mid-request:** assert Reset=0 while in REQ -> Select=0, Cursor=0, SelState=IDLE at the next edge. Repeat the valid-select scenario with RD_LAT=3 -> Select four cycles after the BtnC sampling edge.

Source files
------------

// File: rtl/card_cursor_select.sv
// Cursor on the 4x4 card grid driven by button pulses; a centre press fetches the card
// under the cursor and requests it from gameplay_sm unless it is already face-up or matched.
module card_cursor_select #(
   parameter int unsigned GRID_W = 4,
   parameter int unsigned GRID_H = 4,
   parameter int unsigned LOC_W  = 4,
   parameter int unsigned DATA_W = 6,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Enable,
   input  logic              BtnL,
   input  logic              BtnR,
   input  logic              BtnU,
   input  logic              BtnD,
   input  logic              BtnC,
   output logic [LOC_W-1:0]  RamAddr,
   input  logic [DATA_W-1:0] RamData,
   output logic              Select,
   output logic [DATA_W-1:0] CardSelectData,
   output logic [LOC_W-1:0]  CardSelectLoc,
   input  logic              Ack,
   output logic [LOC_W-1:0]  Cursor,
   output logic              Reject,
   output logic [1:0]        SelState
);

   localparam int unsigned COL_W     = $clog2(GRID_W);
   localparam int unsigned ROW_W     = $clog2(GRID_H);
   localparam int unsigned CNT_W     = 2;
   localparam int unsigned MATCH_BIT = 5;
   localparam int unsigned FACE_BIT  = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_CHECK = 2'd2,
      S_REQ   = 2'd3
   } state_t;

   state_t              state_q, state_n;
   logic [LOC_W-1:0]    cursor_q, cursor_n;
   logic [LOC_W-1:0]    loc_q, loc_n;
   logic [DATA_W-1:0]   data_q, data_n;
   logic                select_q, select_n;
   logic                reject_q, reject_n;
   logic [CNT_W-1:0]    cnt_q, cnt_n;
   logic [COL_W-1:0]    col, col_n;
   logic [ROW_W-1:0]    row, row_n;

   // Power-of-two grid: row/col fields wrap naturally in their own widths.
   assign col = cursor_q[COL_W-1:0];
   assign row = cursor_q[COL_W +: ROW_W];

   always_comb begin
      state_n  = state_q;
      loc_n    = loc_q;
      data_n   = data_q;
      select_n = select_q;
      reject_n = 1'b0;
      cnt_n    = cnt_q;
      col_n    = col;
      row_n    = row;

      case (state_q)
         S_IDLE: begin
            if (BtnC && Enable) begin
               loc_n   = cursor_q;
               cnt_n   = '0;
               state_n = S_READ;
            end else if (BtnL) begin
               col_n = col - COL_W'(1);
            end else if (BtnR) begin
               col_n = col + COL_W'(1);
            end else if (BtnU) begin
               row_n = row - ROW_W'(1);
            end else if (BtnD) begin
               row_n = row + ROW_W'(1);
            end
         end
         S_READ: begin
            if (cnt_q == CNT_W'(RD_LAT - 1)) begin
               data_n  = RamData;
               cnt_n   = '0;
               state_n = S_CHECK;
            end else begin
               cnt_n = cnt_q + CNT_W'(1);
            end
         end
         S_CHECK: begin
            if (data_q[MATCH_BIT] || data_q[FACE_BIT]) begin
               reject_n = 1'b1;
               state_n  = S_IDLE;
            end else begin
               select_n = 1'b1;
               state_n  = S_REQ;
            end
         end
         S_REQ: begin
            if (Ack) begin
               select_n = 1'b0;
               state_n  = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase

      cursor_n = {row_n, col_n};
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q  <= S_IDLE;
         cursor_q <= '0;
         loc_q    <= '0;
         data_q   <= '0;
         select_q <= 1'b0;
         reject_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_n;
         cursor_q <= cursor_n;
         loc_q    <= loc_n;
         data_q   <= data_n;
         select_q <= select_n;
         reject_q <= reject_n;
         cnt_q    <= cnt_n;
      end
   end

   assign RamAddr        = cursor_q;
   assign Cursor         = cursor_q;
   assign Select         = select_q;
   assign Reject         = reject_q;
   assign CardSelectData = data_q;
   assign CardSelectLoc  = loc_q;
   assign SelState       = state_q;

endmodule

// File: tb/tb_card_cursor_select.sv
// Bench for card_cursor_select: two instances (read latency 1 and 3) share the buttons and
// Ack; a transaction-level model predicts cursor moves and per-cycle request outcomes.
module tb_card_cursor_select;

   localparam int unsigned GW = 4;
   localparam int unsigned GH = 4;

   logic clk = 1'b0;
   logic reset, enable, btn_l, btn_r, btn_u, btn_d, btn_c, ack;

   logic [3:0] addr1, csl1, cur1, addr3, csl3, cur3;
   logic [5:0] rd1, csd1, rd3, csd3;
   logic       sel1, rej1, sel3, rej3;
   logic [1:0] st1, st3;

   logic [5:0] mem [16];
   logic [5:0] p1;
   logic [5:0] p3 [3];

   int total = 0;
   int bad   = 0;
   int mrow  = 0;
   int mcol  = 0;

   always #5 clk = ~clk;

   card_cursor_select #(.RD_LAT(1)) dut1 (
      .Clk(clk), .Reset(reset), .Enable(enable),
      .BtnL(btn_l), .BtnR(btn_r), .BtnU(btn_u), .BtnD(btn_d), .BtnC(btn_c),
      .RamAddr(addr1), .RamData(rd1), .Select(sel1), .CardSelectData(csd1),
      .CardSelectLoc(csl1), .Ack(ack), .Cursor(cur1), .Reject(rej1), .SelState(st1)
   );

   card_cursor_select #(.RD_LAT(3)) dut3 (
      .Clk(clk), .Reset(reset), .Enable(enable),
      .BtnL(btn_l), .BtnR(btn_r), .BtnU(btn_u), .BtnD(btn_d), .BtnC(btn_c),
      .RamAddr(addr3), .RamData(rd3), .Select(sel3), .CardSelectData(csd3),
      .CardSelectLoc(csl3), .Ack(ack), .Cursor(cur3), .Reject(rej3), .SelState(st3)
   );

   // Board memory with 1- and 3-cycle read pipelines.
   always @(posedge clk) begin
      p1    <= mem[addr1];
      p3[0] <= mem[addr3];
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign rd1 = p1;
   assign rd3 = p3[2];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int cur_loc();
      return mrow * GW + mcol;
   endfunction

   // Request is live from edge L+1 until the first edge after that which samples Ack.
   function automatic bit exp_sel(int k, int lat, bit badc, int a1, int a3);
      if (badc || k < lat + 1) return 1'b0;
      for (int j = lat + 2; j <= k; j++)
         if (j == a1 || j == a3) return 1'b0;
      return 1'b1;
   endfunction

   task automatic chk_dut(input string nm, input int lat, input int k, input bit badc,
                          input logic [5:0] w, input int loc, input int a1, input int a3,
                          input logic s, input logic r, input logic [1:0] st,
                          input logic [5:0] d, input logic [3:0] l, input logic [3:0] c);
      bit es;
      int est;
      es = exp_sel(k, lat, badc, a1, a3);
      if (k < lat)       est = 1;
      else if (k == lat) est = 2;
      else               est = es ? 3 : 0;
      check($sformatf("%s.select@%0d", nm, k), 32'(s), 32'(es));
      check($sformatf("%s.reject@%0d", nm, k), 32'(r), 32'(badc && k == lat + 1));
      check($sformatf("%s.state@%0d", nm, k), 32'(st), 32'(est));
      check($sformatf("%s.loc@%0d", nm, k), 32'(l), 32'(loc));
      check($sformatf("%s.cursor@%0d", nm, k), 32'(c), 32'(loc));
      if (k >= lat) check($sformatf("%s.data@%0d", nm, k), 32'(d), 32'(w));
   endtask

   // Centre press at edge 0; Ack pulses land on edges a1 and a3 (good cards only).
   task automatic do_select(input int a1, input int a3, input logic [3:0] extra);
      logic [5:0] w;
      bit badc;
      int loc, n, blim;
      loc  = cur_loc();
      w    = mem[loc];
      badc = w[5] | w[4];
      n    = badc ? 6 : a3 + 1;
      blim = badc ? 2 : a1;
      enable = 1'b1;
      btn_c  = 1'b1;
      {btn_l, btn_r, btn_u, btn_d} = extra;
      ack = 1'b0;
      for (int k = 0; k <= n; k++) begin
         tick();
         chk_dut("d1", 1, k, badc, w, loc, a1, a3, sel1, rej1, st1, csd1, csl1, cur1);
         chk_dut("d3", 3, k, badc, w, loc, a1, a3, sel3, rej3, st3, csd3, csl3, cur3);
         if (k + 1 <= blim) {btn_l, btn_r, btn_u, btn_d, btn_c} = 5'($urandom);
         else               {btn_l, btn_r, btn_u, btn_d, btn_c} = 5'b0;
         enable = ((k + 1) % 2 == 0);
         ack    = !badc && (k + 1 == a1 || k + 1 == a3);
      end
      enable = 1'b1;
      {btn_l, btn_r, btn_u, btn_d, btn_c} = 5'b0;
      ack = 1'b0;
   endtask

   // One IDLE cycle with move buttons {L,R,U,D}; BtnC only with Enable low.
   task automatic do_move(input logic [3:0] mv, input logic c, input logic a);
      int loc;
      {btn_l, btn_r, btn_u, btn_d} = mv;
      btn_c  = c;
      enable = 1'b0;
      ack    = a;
      tick();
      {btn_l, btn_r, btn_u, btn_d, btn_c} = 5'b0;
      ack    = 1'b0;
      enable = 1'b1;
      if (mv[3])      mcol = (mcol + GW - 1) % GW;
      else if (mv[2]) mcol = (mcol + 1) % GW;
      else if (mv[1]) mrow = (mrow + GH - 1) % GH;
      else if (mv[0]) mrow = (mrow + 1) % GH;
      loc = cur_loc();
      check("mv.cursor1", 32'(cur1), 32'(loc));
      check("mv.addr1", 32'(addr1), 32'(loc));
      check("mv.state1", 32'(st1), 32'd0);
      check("mv.select1", 32'(sel1), 32'd0);
      check("mv.cursor3", 32'(cur3), 32'(loc));
      check("mv.state3", 32'(st3), 32'd0);
      check("mv.reject3", 32'(rej3), 32'd0);
   endtask

   task automatic chk_reset(input string tag);
      check({tag, ".cursor1"}, 32'(cur1), 32'd0);
      check({tag, ".select1"}, 32'(sel1), 32'd0);
      check({tag, ".reject1"}, 32'(rej1), 32'd0);
      check({tag, ".state1"}, 32'(st1), 32'd0);
      check({tag, ".cursor3"}, 32'(cur3), 32'd0);
      check({tag, ".select3"}, 32'(sel3), 32'd0);
      check({tag, ".state3"}, 32'(st3), 32'd0);
   endtask

   initial begin
      int a1, a3;
      for (int i = 0; i < 16; i++) mem[i] = 6'(i);
      mem[2] = 6'h23;
      mem[3] = 6'h17;
      mem[4] = 6'h05;
      mem[6] = 6'h0A;
      reset = 1'b0; enable = 1'b0; ack = 1'b0;
      {btn_l, btn_r, btn_u, btn_d, btn_c} = 5'b0;
      tick();
      tick();
      chk_reset("rst");
      check("rst.data1", 32'(csd1), 32'd0);
      check("rst.loc1", 32'(csl1), 32'd0);
      check("rst.data3", 32'(csd3), 32'd0);
      reset  = 1'b1;
      enable = 1'b1;

      // Wrap-around moves: 0 -> 3 -> 15 -> 3, then to 5.
      do_move(4'b1000, 1'b0, 1'b0);
      do_move(4'b0010, 1'b0, 1'b0);
      do_move(4'b0001, 1'b0, 1'b0);
      do_move(4'b0001, 1'b0, 1'b0);
      do_move(4'b1000, 1'b0, 1'b0);
      do_move(4'b1000, 1'b0, 1'b0);
      // L+R+D from 5 -> 4 only.
      do_move(4'b1101, 1'b0, 1'b0);
      // BtnC beats BtnR in the same cycle.
      do_select(3, 5, 4'b0100);
      do_move(4'b0100, 1'b0, 1'b0);
      do_move(4'b0100, 1'b0, 1'b0);
      // Valid select at 6 with Ack held low five cycles.
      do_select(8, 9, 4'b0000);
      // Matched card at 2, face-up card at 3.
      do_move(4'b0010, 1'b0, 1'b0);
      do_select(0, 0, 4'b0000);
      do_move(4'b0100, 1'b0, 1'b0);
      do_select(0, 0, 4'b0000);
      // BtnC with Enable low and Ack in IDLE have no effect.
      do_move(4'b0000, 1'b1, 1'b0);
      do_move(4'b0000, 1'b0, 1'b1);

      for (int it = 0; it < 60; it++) begin
         int idx;
         idx = int'($urandom_range(0, 15));
         mem[idx] = {1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), 4'($urandom)};
         if ($urandom_range(0, 2) == 0) begin
            a1 = int'($urandom_range(3, 8));
            a3 = ((a1 > 5) ? a1 : 5) + int'($urandom_range(0, 3));
            do_select(a1, a3, 4'($urandom));
         end else begin
            do_move(4'($urandom), 1'($urandom), 1'($urandom));
         end
      end

      // Reset while both instances hold a request.
      mem[cur_loc()] = 6'h09;
      enable = 1'b1;
      btn_c  = 1'b1;
      tick();
      btn_c = 1'b0;
      for (int k = 1; k <= 5; k++) tick();
      check("mid.select1", 32'(sel1), 32'd1);
      check("mid.select3", 32'(sel3), 32'd1);
      reset = 1'b0;
      tick();
      chk_reset("midrst");
      reset = 1'b1;
      mrow  = 0;
      mcol  = 0;
      do_move(4'b0100, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
